// File: rtl/pong_pkg.sv
// Shared constants, FSM state type and bat move rule for the Pong bat logic.
package pong_pkg;

    localparam int H_W       = 9;
    localparam int BAT_LINES = 16;
    localparam int STEP      = 2;
    localparam int Y_INIT    = 112;
    localparam int V_LAST    = 239;
    localparam int Y_MAX     = V_LAST - BAT_LINES + 1;
    localparam int LEFT_X    = 16;
    localparam int RIGHT_X   = 232;
    localparam int BAT_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // One frame of bat motion; 10-bit arithmetic so y+STEP cannot wrap.
    function automatic logic [H_W-1:0] move_y(input logic [H_W-1:0] y,
                                              input logic up,
                                              input logic down);
        logic [H_W:0] y_ext;
        logic [H_W:0] y_sum;
        y_ext  = {1'b0, y};
        y_sum  = y_ext + (H_W+1)'(STEP);
        move_y = y;
        if (up && !down) begin
            move_y = (y_ext < (H_W+1)'(STEP)) ? '0 : y - H_W'(STEP);
        end else if (down && !up) begin
            move_y = (y_sum > (H_W+1)'(Y_MAX)) ? H_W'(Y_MAX) : y_sum[H_W-1:0];
        end
    endfunction

endpackage

// File: rtl/bat_window.sv
// Per-bat vertical window: opens on the hsync of the bat's top line and stays
// open for BAT_LINES hsync periods; cnt is the line offset inside the bat.
module bat_window
    import pong_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           hs_rise,
    input  logic           clear,
    input  logic [H_W-1:0] vpos,
    input  logic [H_W-1:0] y,
    output logic           vbat,
    output logic [3:0]     cnt
);

    localparam logic [3:0] CNT_LAST = 4'(BAT_LINES - 1);

    logic       r_vbat;
    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_vbat <= 1'b0;
            r_cnt  <= 4'd0;
        end else if (hs_rise) begin
            if (!r_vbat) begin
                if (vpos == y) begin
                    r_vbat <= 1'b1;
                    r_cnt  <= 4'd0;
                end
            end else if (r_cnt == CNT_LAST) begin
                // Counter parks at the last line so a closed window cannot restart mid-count.
                r_vbat <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign vbat = r_vbat;
    assign cnt  = r_cnt;

endmodule

// File: rtl/bat_scheduler.sv
// Both Pong bats: per-frame movement at vsync, per-line vertical windows,
// fixed bat columns and one shared segment index selected by column.
module bat_scheduler
    import pong_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [H_W-1:0] hpos,
    input  logic [H_W-1:0] vpos,
    input  logic           hsync,
    input  logic           vsync,
    input  logic           p1_up,
    input  logic           p1_down,
    input  logic           p2_up,
    input  logic           p2_down,
    output logic [H_W-1:0] bat1_y,
    output logic [H_W-1:0] bat2_y,
    output logic           vbat_l,
    output logic           vbat_r,
    output logic           hbat_l,
    output logic           hbat_r,
    output logic [2:0]     bcd,
    output logic           bat_gfx,
    output logic [1:0]     o_dbg_state
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_hsync_q;
    logic           r_vsync_q;
    logic [H_W-1:0] r_bat1_y;
    logic [H_W-1:0] r_bat2_y;
    logic           w_hs_rise;
    logic           w_vs_rise;
    logic           w_hs_win;
    logic           w_clear;
    logic           w_vbat_l;
    logic           w_vbat_r;
    logic [3:0]     w_cnt_l;
    logic [3:0]     w_cnt_r;
    logic           w_hbat_l;
    logic           w_hbat_r;
    logic [2:0]     w_bcd;

    assign w_hs_rise = hsync & ~r_hsync_q;
    assign w_vs_rise = vsync & ~r_vsync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync_q <= 1'b0;
            r_vsync_q <= 1'b0;
        end else begin
            r_hsync_q <= hsync;
            r_vsync_q <= vsync;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_vs_rise) w_state_nxt = UPDATE;
            UPDATE:  w_state_nxt = SCAN;
            SCAN:    if (w_vs_rise) w_state_nxt = UPDATE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_bat1_y <= H_W'(Y_INIT);
            r_bat2_y <= H_W'(Y_INIT);
        end else begin
            r_state <= w_state_nxt;
            if (r_state == UPDATE) begin
                r_bat1_y <= move_y(r_bat1_y, p1_up, p1_down);
                r_bat2_y <= move_y(r_bat2_y, p2_up, p2_down);
            end
        end
    end

    // A vsync edge in the same clock masks the hsync edge.
    assign w_clear  = (r_state == UPDATE);
    assign w_hs_win = w_hs_rise & (r_state == SCAN) & ~w_vs_rise;

    bat_window u_win_l (
        .clk     (clk),
        .reset   (reset),
        .hs_rise (w_hs_win),
        .clear   (w_clear),
        .vpos    (vpos),
        .y       (r_bat1_y),
        .vbat    (w_vbat_l),
        .cnt     (w_cnt_l)
    );

    bat_window u_win_r (
        .clk     (clk),
        .reset   (reset),
        .hs_rise (w_hs_win),
        .clear   (w_clear),
        .vpos    (vpos),
        .y       (r_bat2_y),
        .vbat    (w_vbat_r),
        .cnt     (w_cnt_r)
    );

    assign w_hbat_l = (hpos >= H_W'(LEFT_X))  && (hpos < H_W'(LEFT_X + BAT_W));
    assign w_hbat_r = (hpos >= H_W'(RIGHT_X)) && (hpos < H_W'(RIGHT_X + BAT_W));

    // Single segment index: left column wins, then right; closed window reads 0.
    always_comb begin
        w_bcd = 3'd0;
        if (w_hbat_l) begin
            if (w_vbat_l) w_bcd = 3'(w_cnt_l >> 1);
        end else if (w_hbat_r) begin
            if (w_vbat_r) w_bcd = 3'(w_cnt_r >> 1);
        end
    end

    assign bat1_y      = r_bat1_y;
    assign bat2_y      = r_bat2_y;
    assign vbat_l      = w_vbat_l;
    assign vbat_r      = w_vbat_r;
    assign hbat_l      = w_hbat_l;
    assign hbat_r      = w_hbat_r;
    assign bcd         = w_bcd;
    assign bat_gfx     = (w_vbat_l & w_hbat_l) | (w_vbat_r & w_hbat_r);
    assign o_dbg_state = r_state;

endmodule
